// File: rtl/ifm_fetch_pkg.sv
// Shared types and constants for the IFM fetch controller slice.
// The FSM state type, the word size in bytes and the default widths live here.
package ifm_fetch_pkg;

  localparam int BYTES_PER_WORD    = 16;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 128;
  localparam int DEF_FIFO_DEPTH    = 4;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_FETCH_ENC  = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC  = 2'd2;
  localparam logic [1:0] ST_FINISH_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_FETCH  = ST_FETCH_ENC,
    ST_DRAIN  = ST_DRAIN_ENC,
    ST_FINISH = ST_FINISH_ENC
  } fetch_state_e;

endpackage

// File: rtl/ifm_fetch_if.sv
// Bus bundle for the IFM fetch controller: tile command/status, BRAM port and PE-array stream.
// The slave modport is the controller's view; master is the surrounding system's view.
interface ifm_fetch_if
  import ifm_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) ();

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [15:0]              row_words;
  logic [15:0]              num_rows;
  logic [ADDRESS_WIDTH-1:0] row_pitch;
  logic                     busy;
  logic                     done;

  logic [ADDRESS_WIDTH-1:0] ifm_address;
  logic                     ifm_address_valid;
  logic                     write_en;
  logic [DATA_WIDTH-1:0]    ifm_out;

  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     data_ready;

  modport master (
    output start, base_addr, row_words, num_rows, row_pitch, ifm_out, data_ready,
    input  busy, done, ifm_address, ifm_address_valid, write_en, data_out, data_valid
  );

  modport slave (
    input  start, base_addr, row_words, num_rows, row_pitch, ifm_out, data_ready,
    output busy, done, ifm_address, ifm_address_valid, write_en, data_out, data_valid
  );

endinterface

// File: rtl/ifm_fetch_fifo.sv
// First-word-fall-through synchronous FIFO with async reset; the head word is presented
// on pop_data_o whenever count_o is non-zero, and reads as zero while empty.
module ifm_fetch_fifo
  import ifm_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q;
  logic [PTR_W-1:0]      rdPtr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  full;
  logic                  doPush;
  logic                  doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign doPop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign doPush = push_i && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o    = (count_q != '0);
  assign pop_data_o = valid_o ? mem_q[rdPtr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM tile fetch controller: walks a 2-D tile in BRAM and streams the words to the PE array.
// Define IFM_FETCH_PERF_EN to add the perf_stall_cycles issue-stall counter output.
module ifm_fetch_ctrl
  import ifm_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  ifm_fetch_if.slave  bus
`ifdef IFM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e             state_q;
  fetch_state_e             state_d;
  logic [15:0]              rowWords_q;
  logic [15:0]              numRows_q;
  logic [15:0]              colCnt_q;
  logic [15:0]              rowCnt_q;
  logic [ADDRESS_WIDTH-1:0] pitch_q;
  logic [ADDRESS_WIDTH-1:0] rowStart_q;
  logic [ADDRESS_WIDTH-1:0] colOff_q;
  logic                     inFlight_q;

  logic [CNT_W-1:0]         fifoCount;
  logic                     fifoValid;
  logic                     fifoPop;
  logic [CNT_W:0]           occupancy;
  logic                     canIssue;
  logic                     issue;
  logic                     lastCol;
  logic                     lastRow;
  logic                     lastIssue;
  logic                     startAccept;
  logic                     emptyTile;

  // Words already buffered plus the one read still returning must never exceed the buffer.
  assign occupancy   = {1'b0, fifoCount} + (CNT_W + 1)'(inFlight_q);
  assign canIssue    = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign issue       = (state_q == ST_FETCH) && canIssue;
  assign lastCol     = (colCnt_q == rowWords_q - 16'd1);
  assign lastRow     = (rowCnt_q == numRows_q - 16'd1);
  assign lastIssue   = issue && lastCol && lastRow;
  assign startAccept = (state_q == ST_IDLE) && bus.start;
  assign emptyTile   = (bus.row_words == 16'd0) || (bus.num_rows == 16'd0);
  assign fifoPop     = fifoValid && bus.data_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = emptyTile ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (lastIssue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((fifoCount == '0) && !inFlight_q) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address walk: row start advances by the pitch, the column offset by one word, no multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rowWords_q <= '0;
      numRows_q  <= '0;
      colCnt_q   <= '0;
      rowCnt_q   <= '0;
      pitch_q    <= '0;
      rowStart_q <= '0;
      colOff_q   <= '0;
      inFlight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inFlight_q <= issue;
      if (startAccept) begin
        rowWords_q <= bus.row_words;
        numRows_q  <= bus.num_rows;
        pitch_q    <= bus.row_pitch;
        rowStart_q <= bus.base_addr;
        colOff_q   <= '0;
        colCnt_q   <= '0;
        rowCnt_q   <= '0;
      end else if (issue) begin
        if (lastCol) begin
          colCnt_q   <= '0;
          colOff_q   <= '0;
          rowCnt_q   <= rowCnt_q + 16'd1;
          rowStart_q <= rowStart_q + pitch_q;
        end else begin
          colCnt_q   <= colCnt_q + 16'd1;
          colOff_q   <= colOff_q + ADDRESS_WIDTH'(BYTES_PER_WORD);
        end
      end
    end
  end

  ifm_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inFlight_q),
    .push_data_i (bus.ifm_out),
    .pop_i       (fifoPop),
    .pop_data_o  (bus.data_out),
    .valid_o     (fifoValid),
    .count_o     (fifoCount)
  );

  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_FINISH);
  assign bus.ifm_address       = rowStart_q + colOff_q;
  assign bus.ifm_address_valid = issue;
  assign bus.write_en          = 1'b0;
  assign bus.data_valid        = fifoValid;

`ifdef IFM_FETCH_PERF_EN
  logic [31:0] perfStall_q;

  // Saturating count of FETCH cycles in which the buffer limit held back the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfStall_q <= '0;
    end else if (startAccept) begin
      perfStall_q <= '0;
    end else if ((state_q == ST_FETCH) && !canIssue && (perfStall_q != '1)) begin
      perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perfStall_q;
`endif

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Self-checking bench for ifm_fetch_ctrl: a tile-level model (address list, word queue)
// is checked against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_ifm_fetch_ctrl;
  import ifm_fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifm_fetch_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef IFM_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  ifm_fetch_ctrl #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFM_FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  logic [31:0]   expAddr[$];
  logic [DW-1:0] expData[$];
  logic [31:0]   strobeAddrLog[$];
  int            strobeCycleLog[$];
  int            wordsOut, doneCount, doneCycle, startCycle, maxOutstanding;
  bit            modelBusy;
  bit            prevValid, prevReady, prevDone;
  logic [DW-1:0] prevData;
  int            modelStall;
  int            outstanding, occBefore;
  bit            fetchPhase, strobeHit;
  logic [31:0]   strobeAddr;

  function automatic logic [DW-1:0] dataOf(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0123_4567};
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // BRAM model: read data appears one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    cycleNo <= cycleNo + 1;
    bus.ifm_out <= bus.ifm_address_valid ? dataOf(bus.ifm_address) : {4{32'hDEAD_BEEF}};
  end

  // Per-cycle comparison of the DUT against the tile model.
  always @(negedge clk) begin
    if (rst) begin
      expAddr.delete();
      expData.delete();
      modelBusy  = 1'b0;
      modelStall = 0;
      prevValid  = 1'b0;
      prevReady  = 1'b0;
      prevDone   = 1'b0;
    end else begin
      checkBit("write_en", bus.write_en, 1'b0);
      if (prevValid && !prevReady) begin
        checkBit("hold_valid", bus.data_valid, 1'b1);
        checkData("hold_data", bus.data_out, prevData);
      end
      occBefore  = expData.size();
      fetchPhase = modelBusy && (expAddr.size() != 0);
      strobeHit  = 1'b0;
      if (bus.ifm_address_valid) begin
        checkBit("strobe_pending_addr", expAddr.size() != 0, 1'b1);
        if (expAddr.size() != 0) begin
          strobeAddr = expAddr.pop_front();
          checkWord("ifm_address", bus.ifm_address, strobeAddr);
          strobeAddrLog.push_back(bus.ifm_address);
          strobeCycleLog.push_back(cycleNo);
          strobeHit = 1'b1;
        end
      end
      outstanding = occBefore + (bus.ifm_address_valid ? 1 : 0);
      checkBit("outstanding_le_depth", outstanding <= DEPTH, 1'b1);
      if (outstanding > maxOutstanding) maxOutstanding = outstanding;
      if (bus.data_valid) checkBit("valid_has_word", expData.size() != 0, 1'b1);
      if (bus.data_valid && bus.data_ready && (expData.size() != 0)) begin
        checkData("data_out", bus.data_out, expData.pop_front());
        wordsOut++;
      end
      if (strobeHit) expData.push_back(dataOf(strobeAddr));
      checkBit("busy", bus.busy, modelBusy);
      checkBit("done_single_pulse", prevDone && bus.done, 1'b0);
      if (bus.done) begin
        checkBit("done_while_busy", modelBusy, 1'b1);
        checkInt("done_after_drain", expAddr.size() + expData.size(), 0);
        doneCount++;
        doneCycle = cycleNo;
      end
`ifdef IFM_FETCH_PERF_EN
      checkInt("perf_stall_model", int'(perf_stall_cycles), modelStall);
      if (fetchPhase && (occBefore >= DEPTH)) modelStall++;
`endif
      if (modelBusy && bus.done) begin
        modelBusy = 1'b0;
      end else if (!modelBusy && bus.start) begin
        modelBusy  = 1'b1;
        startCycle = cycleNo;
        modelStall = 0;
      end
      prevValid = bus.data_valid;
      prevReady = bus.data_ready;
      prevData  = bus.data_out;
      prevDone  = bus.done;
    end
  end

  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] rw,
                               input logic [15:0] nr, input logic [31:0] pitch);
    for (int r = 0; r < int'(nr); r++)
      for (int c = 0; c < int'(rw); c++)
        expAddr.push_back(base + 32'(r) * pitch + 32'(c) * 32'd16);
    strobeAddrLog.delete();
    strobeCycleLog.delete();
    wordsOut = 0;
    doneCount = 0;
    maxOutstanding = 0;
    bus.base_addr = base;
    bus.row_words = rw;
    bus.num_rows  = nr;
    bus.row_pitch = pitch;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((doneCount == 0) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    checkBit("done_seen", doneCount != 0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkOutput();
    checkBit("rst_busy", bus.busy, 1'b0);
    checkBit("rst_done", bus.done, 1'b0);
    checkWord("rst_ifm_address", bus.ifm_address, 32'h0);
    checkBit("rst_ifm_address_valid", bus.ifm_address_valid, 1'b0);
    checkBit("rst_write_en", bus.write_en, 1'b0);
    checkBit("rst_data_valid", bus.data_valid, 1'b0);
    checkData("rst_data_out", bus.data_out, '0);
  endtask

  logic [31:0] basicExp [8];
  int n, mark;

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    basicExp = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h180, 32'h190, 32'h1A0, 32'h1B0};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.row_words = '0;
    bus.num_rows = '0;
    bus.row_pitch = '0;
    bus.data_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic tile with a start pulse mid-fetch that must be ignored
    $display("[TB] basic tile");
    applyStimulus(32'h100, 16'd4, 16'd2, 32'h80);
    bus.base_addr = 32'hBAD0;
    bus.row_words = 16'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone(60);
    checkInt("basic_strobes", strobeAddrLog.size(), 8);
    if (strobeAddrLog.size() == 8) begin
      for (int i = 0; i < 8; i++) checkWord("basic_addr_literal", strobeAddrLog[i], basicExp[i]);
      checkInt("basic_first_strobe_latency", strobeCycleLog[0] - startCycle, 1);
      checkInt("basic_consecutive", strobeCycleLog[7] - strobeCycleLog[0], 7);
    end
    checkInt("basic_words", wordsOut, 8);
    checkInt("basic_done_count", doneCount, 1);

    // Backpressure: ready low for 10 cycles mid-tile
    $display("[TB] backpressure");
    applyStimulus(32'h2000, 16'd8, 16'd2, 32'h400);
    repeat (3) begin @(posedge clk); #1; end
    bus.data_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    mark = strobeAddrLog.size();
    repeat (5) begin @(posedge clk); #1; end
    checkInt("bp_stalled_strobes", strobeAddrLog.size() - mark, 0);
    bus.data_ready = 1'b1;
    waitDone(100);
    checkInt("bp_max_outstanding", maxOutstanding, DEPTH);
    checkInt("bp_words", wordsOut, 16);
    checkInt("bp_done_count", doneCount, 1);

    // Empty tiles: zero columns, then zero rows
    $display("[TB] empty tiles");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h500, (k == 0) ? 16'd0 : 16'd2, (k == 0) ? 16'd3 : 16'd0, 32'h40);
      waitDone(10);
      checkInt("empty_strobes", strobeAddrLog.size(), 0);
      checkInt("empty_done_latency", doneCycle - startCycle, 1);
      checkInt("empty_done_count", doneCount, 1);
    end

    // Address wrap-around
    $display("[TB] wrap-around");
    applyStimulus(32'hFFFF_FFF0, 16'd2, 16'd1, 32'h100);
    waitDone(20);
    checkInt("wrap_strobes", strobeAddrLog.size(), 2);
    if (strobeAddrLog.size() == 2) begin
      checkWord("wrap_addr0", strobeAddrLog[0], 32'hFFFF_FFF0);
      checkWord("wrap_addr1", strobeAddrLog[1], 32'h0000_0000);
    end
    checkInt("wrap_words", wordsOut, 2);

    // Reset mid-fetch after three strobes, then a fresh tile
    $display("[TB] reset mid-fetch");
    applyStimulus(32'h3000, 16'd4, 16'd2, 32'h80);
    n = 0;
    while ((strobeAddrLog.size() < 3) && (n < 20)) begin
      @(posedge clk); #1;
      n++;
    end
    checkInt("midrst_strobes_before", strobeAddrLog.size(), 3);
    rst = 1'b1;
    #1;
    checkOutput();
    @(negedge clk);
    checkOutput();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkInt("midrst_no_done", doneCount, 0);
    applyStimulus(32'h4000, 16'd3, 16'd2, 32'h40);
    waitDone(40);
    checkInt("midrst_new_words", wordsOut, 6);
    checkInt("midrst_new_done", doneCount, 1);
    if (strobeAddrLog.size() == 6) begin
      checkWord("midrst_new_first", strobeAddrLog[0], 32'h4000);
      checkWord("midrst_new_last", strobeAddrLog[5], 32'h4060);
    end

`ifdef IFM_FETCH_PERF_EN
    // Stall counter: ready low for 6 blocked FETCH cycles once the buffer is full
    $display("[TB] perf stall counter");
    bus.data_ready = 1'b0;
    applyStimulus(32'h6000, 16'd8, 16'd1, 32'h0);
    n = 0;
    while ((expData.size() < DEPTH) && (n < 20)) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin @(posedge clk); #1; end
    bus.data_ready = 1'b1;
    waitDone(60);
    checkInt("perf_stall_literal", int'(perf_stall_cycles), 6);
    checkInt("perf_words", wordsOut, 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
